ace_ps2_matrix: RTL
===================

Name: ace_ps2_matrix

Overview:
- Converts a PS/2 keyboard (scan code set 2) into the Jupiter Ace 8x5 key matrix.
- Sits directly upstream of the Ace core:
  - takes the row-select lines the core drives from CPU A15..A8 (filas);
  - returns the active-low column lines the core reads at port FE (columnas).
- Contains a filtered PS/2 frame receiver, a prefix/break decoder FSM and a 40-bit key-state register.

Parameters:
FILTER_LEN, 8, consecutive equal samples of synchronised ps2clk needed to accept a new level
TIMEOUT_CYCLES, 16384, clk cycles without a ps2clk falling edge before a partial frame is discarded

Ports:
clk  input  1  system clock; all state clocked on rising edge
reset  input  1  asynchronous, active-low reset
ps2clk  input  1  raw PS/2 clock from connector (asynchronous)
ps2data  input  1  raw PS/2 data from connector (asynchronous)
filas  input  8  row select from core, active low; filas[r] = 0 selects row r
columnas  output  5  column return to core, active low
kbd_error  output  1  one-clk pulse on a rejected frame (parity, stop bit or timeout)

Behaviour:
- Reset (async, low): all internal state cleared.
  - key matrix all released, receiver IDLE, decoder NORMAL.
  - kbd_error = 0; columnas = 5'b11111 for any filas.
- Input conditioning:
  - ps2clk and ps2data each pass through a 2-FF synchroniser.
  - Filtered ps2clk changes level only after FILTER_LEN consecutive equal synchronised samples.
  - Data is sampled on a filtered ps2clk falling edge.
- Receiver frame: start bit 0, 8 data bits LSB first, odd parity, stop bit 1; 11-bit counter.
  - A start bit of 1 is ignored (stays IDLE).
  - Frame completes on the 11th falling edge.
  - Valid frame: byte_valid pulses for 1 clk with the byte.
  - Bad parity or stop bit = 0: byte dropped, kbd_error pulses 1 clk.
  - Timeout: no falling edge for TIMEOUT_CYCLES while mid-frame returns to IDLE and pulses kbd_error. The counter is reset by every falling edge and is inactive in IDLE.
- Decoder FSM, states NORMAL, EXT, BRK, EXTBRK:
  - NORMAL: F0 -> BRK; E0 -> EXT; otherwise apply make(code, ext=0).
  - EXT: F0 -> EXTBRK; otherwise apply make(code, ext=1), -> NORMAL.
  - BRK: apply break(code, ext=0), -> NORMAL.
  - EXTBRK: apply break(code, ext=1), -> NORMAL.
  - E1, AA, FA, EE, FE bytes: ignored; FSM returns to NORMAL.
- Key map, given as row/col with col = bit of columnas:
  - Row 0: CAPS SHIFT c0, SYMBOL SHIFT c1, Z c2, X c3, C c4.
  - Row 1: A S D F G.
  - Row 2: Q W E R T.
  - Row 3: 1 2 3 4 5.
  - Row 4: 0 9 8 7 6.
  - Row 5: P O I U Y.
  - Row 6: ENTER L K J H.
  - Row 7: SPACE SYMSHIFT-independent M N B V, i.e. SPACE c0, M c1, N c2, B c3, V c4.
  - Scan codes: letters and digits use standard set-2 codes (A=1C, Z=1A, Q=15, 1=16, 0=45, etc.), ENTER=5A, SPACE=29.
  - 12 and 59 map to CAPS SHIFT; 14 and E0 14 map to SYMBOL SHIFT.
  - Composite keys set/clear two bits together:
    - 66 backspace = CAPS+0;
    - E0 6B left = CAPS+5;
    - E0 74 right = CAPS+8;
    - E0 75 up = CAPS+7;
    - E0 72 down = CAPS+6.
  - 07 (F12), make only: clears all 40 matrix bits in the same clk.
  - All other codes, including E0 12: no effect.
- Make sets the mapped bit(s); break clears them.
  - Releasing a composite clears CAPS even if a physical shift is still held. This is accepted behaviour; the next shift make restores it.
  - Repeated makes (typematic) are idempotent.
- Output logic: columnas[c] = ~OR over r of (matrix[r][c] AND ~filas[r]).
  - Purely combinational from filas and the matrix register, so the core sees a new row selection in the same cycle.
  - Multiple selected rows OR together.
- Matrix update latency: a bit changes on the clk after byte_valid.
- A reset mid-frame or mid-prefix discards everything.

Test Plan:
- Reset low with filas=8'h00 -> columnas=5'b11111, kbd_error=0; release reset, send nothing -> unchanged.
- Send frame 1C (A make), filas=8'hFD -> columnas=5'b11110; filas=8'hFE -> 5'b11111; then F0 1C -> columnas=5'b11111 with filas=8'hFD.
- Send 66 (backspace), filas=8'hFE -> 5'b11110; filas=8'hEF -> 5'b11110; filas=8'hEE -> 5'b11110; after F0 66 -> 5'b11111 for both rows.
- Send E0 14 -> filas=8'hFE gives 5'b11101; send E0 F0 14 -> 5'b11111; send E0 12 -> no matrix change.
- Frame 1A with even parity -> kbd_error one-clk pulse, matrix unchanged. Start a frame, stop ps2clk after 4 bits for TIMEOUT_CYCLES+1 -> kbd_error pulse, then valid 1A frame -> row 0 column 2 low.
- Press 1C, 15, 29, then 07 -> all rows read 5'b11111 with filas=8'h00. Glitch of FILTER_LEN-1 clk on ps2clk -> no bit sampled.

Source files
------------

// File: rtl/ace_ps2_matrix.sv
// ace_ps2_matrix: PS/2 set-2 keyboard to Jupiter Ace 8x5 key matrix.
//   clk       system clock
//   reset     asynchronous active-low reset
//   ps2clk    raw PS/2 clock (asynchronous)
//   ps2data   raw PS/2 data (asynchronous)
//   filas     active-low row select from the core
//   columnas  active-low column return to the core
//   kbd_error one-clk pulse on a rejected frame (parity, stop bit, timeout)
module ace_ps2_matrix #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 16384
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2clk,
    input  logic       ps2data,
    input  logic [7:0] filas,
    output logic [4:0] columnas,
    output logic       kbd_error
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {NORMAL, EXT, BRK, EXTBRK} dec_t;

    logic [1:0]    clk_s_q, dat_s_q;
    logic          filt_q;
    logic [FW-1:0] fcnt_q;
    logic          busy_q;
    logic [3:0]    bcnt_q;
    logic [8:0]    sh_q;
    logic [TW-1:0] tmo_q;
    logic          bv_q, err_q;
    logic [7:0]    byte_q;
    dec_t          st_q, st_d;
    logic [39:0]   mat_q, mat_d, mask;
    logic          flip, fall, ok;

    // Filter flips on the FILTER_LEN-th consecutive sample that disagrees with it
    assign flip = (clk_s_q[1] != filt_q) && (fcnt_q == FW'(FILTER_LEN - 1));
    assign fall = flip & filt_q;
    // On the 11th edge: sh_q holds {parity, data}, the live data bit is the stop bit
    assign ok = dat_s_q[1] & (^sh_q);
    assign kbd_error = err_q;

    // Bit index is row*5 + col
    function automatic logic [39:0] key_mask(input logic ext, input logic [7:0] code);
        case ({ext, code})
            9'h012, 9'h059: key_mask = 40'd1 << 0;
            9'h014, 9'h114: key_mask = 40'd1 << 1;
            9'h01A: key_mask = 40'd1 << 2;
            9'h022: key_mask = 40'd1 << 3;
            9'h021: key_mask = 40'd1 << 4;
            9'h01C: key_mask = 40'd1 << 5;
            9'h01B: key_mask = 40'd1 << 6;
            9'h023: key_mask = 40'd1 << 7;
            9'h02B: key_mask = 40'd1 << 8;
            9'h034: key_mask = 40'd1 << 9;
            9'h015: key_mask = 40'd1 << 10;
            9'h01D: key_mask = 40'd1 << 11;
            9'h024: key_mask = 40'd1 << 12;
            9'h02D: key_mask = 40'd1 << 13;
            9'h02C: key_mask = 40'd1 << 14;
            9'h016: key_mask = 40'd1 << 15;
            9'h01E: key_mask = 40'd1 << 16;
            9'h026: key_mask = 40'd1 << 17;
            9'h025: key_mask = 40'd1 << 18;
            9'h02E: key_mask = 40'd1 << 19;
            9'h045: key_mask = 40'd1 << 20;
            9'h046: key_mask = 40'd1 << 21;
            9'h03E: key_mask = 40'd1 << 22;
            9'h03D: key_mask = 40'd1 << 23;
            9'h036: key_mask = 40'd1 << 24;
            9'h04D: key_mask = 40'd1 << 25;
            9'h044: key_mask = 40'd1 << 26;
            9'h043: key_mask = 40'd1 << 27;
            9'h03C: key_mask = 40'd1 << 28;
            9'h035: key_mask = 40'd1 << 29;
            9'h05A: key_mask = 40'd1 << 30;
            9'h04B: key_mask = 40'd1 << 31;
            9'h042: key_mask = 40'd1 << 32;
            9'h03B: key_mask = 40'd1 << 33;
            9'h033: key_mask = 40'd1 << 34;
            9'h029: key_mask = 40'd1 << 35;
            9'h03A: key_mask = 40'd1 << 36;
            9'h031: key_mask = 40'd1 << 37;
            9'h032: key_mask = 40'd1 << 38;
            9'h02A: key_mask = 40'd1 << 39;
            9'h066: key_mask = (40'd1 << 0) | (40'd1 << 20);
            9'h16B: key_mask = (40'd1 << 0) | (40'd1 << 19);
            9'h174: key_mask = (40'd1 << 0) | (40'd1 << 22);
            9'h175: key_mask = (40'd1 << 0) | (40'd1 << 23);
            9'h172: key_mask = (40'd1 << 0) | (40'd1 << 24);
            default: key_mask = '0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_s_q <= 2'b11;
            dat_s_q <= 2'b11;
            filt_q  <= 1'b1;
            fcnt_q  <= '0;
        end else begin
            clk_s_q <= {clk_s_q[0], ps2clk};
            dat_s_q <= {dat_s_q[0], ps2data};
            filt_q  <= flip ? ~filt_q : filt_q;
            fcnt_q  <= (clk_s_q[1] == filt_q || flip) ? '0 : fcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= 1'b0;
            bcnt_q <= '0;
            sh_q   <= '0;
            tmo_q  <= '0;
            bv_q   <= 1'b0;
            err_q  <= 1'b0;
            byte_q <= '0;
        end else begin
            bv_q  <= 1'b0;
            err_q <= 1'b0;
            if (busy_q && fall) begin
                tmo_q <= '0;
                sh_q  <= {dat_s_q[1], sh_q[8:1]};
                if (bcnt_q == 4'd10) begin
                    busy_q <= 1'b0;
                    bcnt_q <= '0;
                    byte_q <= sh_q[7:0];
                    bv_q   <= ok;
                    err_q  <= ~ok;
                end else begin
                    bcnt_q <= bcnt_q + 1'b1;
                end
            end else if (busy_q && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                busy_q <= 1'b0;
                bcnt_q <= '0;
                tmo_q  <= '0;
                err_q  <= 1'b1;
            end else if (busy_q) begin
                tmo_q <= tmo_q + 1'b1;
            end else if (fall && !dat_s_q[1]) begin
                busy_q <= 1'b1;
                bcnt_q <= 4'd1;
                tmo_q  <= '0;
            end
        end
    end

    always_comb begin
        mask  = key_mask(st_q == EXT || st_q == EXTBRK, byte_q);
        st_d  = st_q;
        mat_d = mat_q;
        if (bv_q) begin
            if (byte_q inside {8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE}) begin
                st_d = NORMAL;
            end else if (byte_q == 8'hF0 && (st_q == NORMAL || st_q == EXT)) begin
                st_d = (st_q == NORMAL) ? BRK : EXTBRK;
            end else if (byte_q == 8'hE0 && st_q == NORMAL) begin
                st_d = EXT;
            end else begin
                st_d  = NORMAL;
                mat_d = (st_q == BRK || st_q == EXTBRK) ? (mat_q & ~mask) :
                        (st_q == NORMAL && byte_q == 8'h07) ? '0 : (mat_q | mask);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q  <= NORMAL;
            mat_q <= '0;
        end else begin
            st_q  <= st_d;
            mat_q <= mat_d;
        end
    end

    always_comb begin
        columnas = '1;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 5; c++)
                if (!filas[r] && mat_q[r*5+c]) columnas[c] = 1'b0;
    end
endmodule
